// File: rtl/diagv2_ecall_unit.sv
// diagv2_ecall_unit
//   Hardware responder to the core's ecall request. Stalls the core, decodes the syscall
//   number (a7) and first argument (a0), and services:
//     EXIT  (93): latch a0 as exit code, halt permanently.
//     PRINT (4) : walk a NUL-terminated string in dmem through a spare read port and
//                 stream its bytes out over a valid/ready byte interface.
//   Any other syscall number flags an error and halts.
//
// Ports
//   clk, reset     clock and synchronous active-high reset
//   ecall_i        ecall request level, held by the core until ecall_ack_o
//   syscall_i      a7 value, valid while ecall_i
//   arg0_i         a0 value, valid while ecall_i
//   stall_o        freeze the core pipeline
//   ecall_ack_o    one-cycle pulse when the ecall retires
//   mem_req_o      dmem read strobe
//   mem_addr_o     dmem line index
//   mem_rdata_i    dmem line, valid exactly one cycle after mem_req_o
//   tx_valid_o     output byte available
//   tx_data_o      output byte value
//   tx_ready_i     sink accepts the byte
//   halted_o       sticky, set by EXIT or an invalid syscall
//   exit_code_o    a0 latched at EXIT
//   err_o          sticky, set by an invalid syscall or a PRINT truncated at MAX_STR

module diagv2_ecall_unit #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned LINE_AW = 12,
    parameter int unsigned MAX_STR = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ecall_i,
    input  logic [DATA_W-1:0]  syscall_i,
    input  logic [DATA_W-1:0]  arg0_i,
    output logic               stall_o,
    output logic               ecall_ack_o,
    output logic               mem_req_o,
    output logic [LINE_AW-1:0] mem_addr_o,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    output logic               tx_valid_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_ready_i,
    output logic               halted_o,
    output logic [DATA_W-1:0]  exit_code_o,
    output logic               err_o
);

    localparam int unsigned CntW = $clog2(MAX_STR + 1);

    localparam logic [DATA_W-1:0] SysExit  = DATA_W'(93);
    localparam logic [DATA_W-1:0] SysPrint = DATA_W'(4);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StEmit,
        StDone,
        StHalt
    } state_e;

    state_e              state_q, state_d;
    logic [LINE_AW-1:0]  line_q, line_d;
    logic [2:0]          off_q, off_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                halted_q, halted_d;
    logic [DATA_W-1:0]   exit_q, exit_d;
    logic                err_q, err_d;

    logic [2:0]          off_inc;
    logic [7:0]          rd_byte;
    logic [7:0]          nxt_byte;
    logic [CntW-1:0]     cnt_inc;

    assign off_inc  = off_q + 3'd1;
    assign cnt_inc  = cnt_q + CntW'(1);
    // Byte at the current offset in the line arriving from dmem this cycle.
    assign rd_byte  = mem_rdata_i[{off_q, 3'b000} +: 8];
    // Following byte from the buffered line, used while staying within that line.
    assign nxt_byte = buf_q[{off_inc, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            line_q     <= '0;
            off_q      <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            halted_q   <= 1'b0;
            exit_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            off_q      <= off_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            halted_q   <= halted_d;
            exit_q     <= exit_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        halted_d   = halted_q;
        exit_d     = exit_q;
        err_d      = err_q;

        case (state_q)
            StIdle: begin
                if (ecall_i && !halted_q) begin
                    if (syscall_i == SysExit) begin
                        exit_d   = arg0_i;
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end else if (syscall_i == SysPrint) begin
                        line_d  = arg0_i[LINE_AW+2:3];
                        off_d   = arg0_i[2:0];
                        cnt_d   = '0;
                        state_d = StFetch;
                    end else begin
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end
                end
            end
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                buf_d = mem_rdata_i;
                if (rd_byte == 8'h00) begin
                    state_d = StDone;
                end else begin
                    tx_data_d  = rd_byte;
                    tx_valid_d = 1'b1;
                    state_d    = StEmit;
                end
            end
            StEmit: begin
                if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    cnt_d      = cnt_inc;
                    off_d      = off_inc;
                    if (cnt_inc == CntW'(MAX_STR)) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (off_q == 3'd7) begin
                        // Line exhausted: the buffer is stale, refetch from the next line.
                        line_d  = line_q + LINE_AW'(1);
                        state_d = StFetch;
                    end else if (nxt_byte == 8'h00) begin
                        state_d = StDone;
                    end else begin
                        tx_data_d  = nxt_byte;
                        tx_valid_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign stall_o     = ((state_q == StIdle) && ecall_i && !halted_q) ||
                         ((state_q != StIdle) && (state_q != StDone));
    assign ecall_ack_o = (state_q == StDone);
    assign mem_req_o   = (state_q == StFetch);
    assign mem_addr_o  = line_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign halted_o    = halted_q;
    assign exit_code_o = exit_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_diagv2_ecall_unit.sv
// Directed testbench for diagv2_ecall_unit. MAX_STR is set to 4 so that string
// truncation can be exercised with short strings; all other strings are <= 3 bytes.

module tb_diagv2_ecall_unit;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 12;
    localparam int unsigned MS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ecall = 1'b0;
    logic [DW-1:0] syscall = '0;
    logic [DW-1:0] arg0 = '0;
    logic          stall;
    logic          ecall_ack;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b1;
    logic          halted;
    logic [DW-1:0] exit_code;
    logic          err;

    always #5 clk = ~clk;

    diagv2_ecall_unit #(
        .DATA_W  (DW),
        .LINE_AW (AW),
        .MAX_STR (MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ecall_i     (ecall),
        .syscall_i   (syscall),
        .arg0_i      (arg0),
        .stall_o     (stall),
        .ecall_ack_o (ecall_ack),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .halted_o    (halted),
        .exit_code_o (exit_code),
        .err_o       (err)
    );

    // Data memory: one-cycle registered read.
    logic [DW-1:0] mem [0:15];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[3:0]];
    end

    // Monitors for transferred bytes and issued fetches.
    logic [7:0]    rx_buf [0:63];
    int            rx_n = 0;
    logic [AW-1:0] fetch_addr [0:31];
    int            fetch_n = 0;

    always @(posedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) begin
                if (rx_n < 64) rx_buf[rx_n] <= tx_data;
                rx_n <= rx_n + 1;
            end
            if (mem_req) begin
                if (fetch_n < 32) fetch_addr[fetch_n] <= mem_addr;
                fetch_n <= fetch_n + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rx(input string tag, input int base, input string s);
        check({tag, "_len"}, 64'(rx_n - base), 64'(s.len()));
        for (int i = 0; i < s.len(); i++) begin
            if (base + i < 64) check(tag, {56'd0, rx_buf[base + i]}, {56'd0, s[i]});
        end
    endtask

    // Raise an ecall and wait (bounded) for the ack. When stall_byte >= 0, the sink
    // withholds tx_ready for 5 cycles while that byte index is presented and checks
    // the byte stays stable.
    task automatic run_ecall(input logic [63:0] sys, input logic [63:0] a0,
                             input int stall_byte, input bit expect_ack,
                             input int budget, output int cycles);
        int         base;
        int         hold;
        logic [7:0] held;
        bit         acked;
        @(negedge clk);
        base    = rx_n;
        syscall = sys;
        arg0    = a0;
        ecall   = 1'b1;
        cycles  = 0;
        acked   = 1'b0;
        hold    = 0;
        held    = '0;
        while (!acked && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (ecall_ack) begin
                acked = 1'b1;
                check("ack_stall", {63'd0, stall}, 64'd0);
                ecall = 1'b0;
            end else if (hold > 0 && hold < 5) begin
                check("hold_valid", {63'd0, tx_valid}, 64'd1);
                check("hold_data", {56'd0, tx_data}, {56'd0, held});
                hold++;
                tx_ready = 1'b0;
            end else if (hold == 0 && tx_valid && (rx_n - base) == stall_byte) begin
                held     = tx_data;
                hold     = 1;
                tx_ready = 1'b0;
            end else begin
                tx_ready = 1'b1;
            end
        end
        ecall    = 1'b0;
        tx_ready = 1'b1;
        check("ack_seen", {63'd0, acked}, {63'd0, expect_ack});
        if (acked) begin
            @(negedge clk);
            check("ack_pulse", {63'd0, ecall_ack}, 64'd0);
            check("idle_stall", {63'd0, stall}, 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, {63'd0, stall}, 64'd0);
        check({tag, "_ack"}, {63'd0, ecall_ack}, 64'd0);
        check({tag, "_req"}, {63'd0, mem_req}, 64'd0);
        check({tag, "_addr"}, {52'd0, mem_addr}, 64'd0);
        check({tag, "_txv"}, {63'd0, tx_valid}, 64'd0);
        check({tag, "_txd"}, {56'd0, tx_data}, 64'd0);
        check({tag, "_halt"}, {63'd0, halted}, 64'd0);
        check({tag, "_exit"}, exit_code, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ecall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    int cyc;
    int base;
    int fbase;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // 1: PRINT "Hi\n" from line 2 offset 3, single fetch
        mem[2] = 64'h2E_00_0A_69_48_11_11_11;
        base = rx_n; fbase = fetch_n;
        run_ecall(64'd4, 64'h13, -1, 1'b1, 40, cyc);
        check_rx("t1_rx", base, "Hi\n");
        check("t1_nfetch", 64'(fetch_n - fbase), 64'd1);
        check("t1_faddr", {52'd0, fetch_addr[fbase]}, 64'd2);
        check("t1_err", {63'd0, err}, 64'd0);
        check("t1_halt", {63'd0, halted}, 64'd0);

        // 1b: NUL at arg0 -> ack three cycles after accept, nothing emitted
        mem[3] = 64'h11_11_11_11_11_11_11_00;
        base = rx_n; fbase = fetch_n;
        run_ecall(64'd4, 64'h18, -1, 1'b1, 40, cyc);
        check("t1b_latency", 64'(cyc), 64'd3);
        check("t1b_ntx", 64'(rx_n - base), 64'd0);
        check("t1b_faddr", {52'd0, fetch_addr[fbase]}, 64'd3);

        // 2+3: "ABC" across lines 1-2, sink stalls 5 cycles on the 2nd byte
        mem[1] = 64'h42_41_00_00_00_00_00_00;
        mem[2] = 64'h55_55_55_55_55_55_00_43;
        base = rx_n; fbase = fetch_n;
        run_ecall(64'd4, 64'h0E, 1, 1'b1, 60, cyc);
        check_rx("t2_rx", base, "ABC");
        check("t2_nfetch", 64'(fetch_n - fbase), 64'd2);
        check("t2_faddr0", {52'd0, fetch_addr[fbase]}, 64'd1);
        check("t2_faddr1", {52'd0, fetch_addr[fbase + 1]}, 64'd2);

        // 5b: 10-byte string truncated at MAX_STR=4
        mem[4] = 64'h37_36_35_34_33_32_31_30;
        mem[5] = 64'h00_00_00_00_00_00_39_38;
        base = rx_n; fbase = fetch_n;
        run_ecall(64'd4, 64'h20, -1, 1'b1, 60, cyc);
        check_rx("t5b_rx", base, "0123");
        check("t5b_err", {63'd0, err}, 64'd1);
        check("t5b_halt", {63'd0, halted}, 64'd0);
        check("t5b_nfetch", 64'(fetch_n - fbase), 64'd1);

        // 6: reset during EMIT, then a fresh PRINT
        mem[2] = 64'h2E_00_0A_69_48_11_11_11;
        @(negedge clk);
        tx_ready = 1'b0;
        syscall  = 64'd4;
        arg0     = 64'h13;
        ecall    = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_txv", {63'd0, tx_valid}, 64'd1);
        check("t6_txd", {56'd0, tx_data}, 64'h48);
        reset = 1'b1;
        ecall = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        reset    = 1'b0;
        tx_ready = 1'b1;
        base = rx_n;
        run_ecall(64'd4, 64'h13, -1, 1'b1, 40, cyc);
        check_rx("t6_rx", base, "Hi\n");

        // 4: EXIT halts, later ecalls ignored
        run_ecall(64'd93, 64'h2A, -1, 1'b0, 10, cyc);
        check("t4_halt", {63'd0, halted}, 64'd1);
        check("t4_exit", exit_code, 64'h2A);
        check("t4_stall", {63'd0, stall}, 64'd1);
        check("t4_err", {63'd0, err}, 64'd0);
        base = rx_n; fbase = fetch_n;
        run_ecall(64'd4, 64'h13, -1, 1'b0, 10, cyc);
        check("t4_nfetch", 64'(fetch_n - fbase), 64'd0);
        check("t4_ntx", 64'(rx_n - base), 64'd0);
        check("t4_stall2", {63'd0, stall}, 64'd1);
        check("t4_exit2", exit_code, 64'h2A);

        // 5a: invalid syscall
        do_reset();
        base = rx_n; fbase = fetch_n;
        run_ecall(64'd7, 64'h0, -1, 1'b0, 10, cyc);
        check("t5a_err", {63'd0, err}, 64'd1);
        check("t5a_halt", {63'd0, halted}, 64'd1);
        check("t5a_ntx", 64'(rx_n - base), 64'd0);
        check("t5a_nfetch", 64'(fetch_n - fbase), 64'd0);
        check("t5a_exit", exit_code, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
